vga_scan_engine: RTL and testbench
==================================

VGA_SCAN_ENGINE -- requirements
Module: vga_scan_engine

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48, visible/front-porch/sync/back-porch pixels per line.
REQ-002 SHALL have parameters: V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, visible/front-porch/sync/back-porch lines per frame.
REQ-003 SHALL have parameters: SCALE 1, pixel replication factor (1, 2 or 4, both axes); RD_LAT 1, framebuffer read latency in cycles (1..4); HS_POL 0, VS_POL 0, active sync level; CW 10, x/y counter width.
REQ-004 SHALL use one clock and asynchronous active-high reset; ports in order below.
REQ-005 clk  in  1  pixel clock (PLL external to this block).
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 en  in  1  scan enable, sampled only at frame boundary.
REQ-008 mode  in  1  0 = RGB332 expansion, 1 = 8-bit grayscale; sampled at frame boundary.
REQ-009 fb_rd, fb_addr  out  1, ADDR_W  read strobe and address; ADDR_W = clog2((H_ACTIVE/SCALE)*(V_ACTIVE/SCALE)).
REQ-010 pixel  in  8  framebuffer data, valid RD_LAT cycles after fb_rd.
REQ-011 h_sync, v_sync, sync_b, blank_b  out  1 each  VGA timing; sync_b tied 0.
REQ-012 red, green, blue  out  8 each  DAC colour.
REQ-013 x, y  out  CW each  coordinate of pixel currently on outputs.
REQ-014 frame_start  out  1  one-cycle pulse with pixel (0,0) on outputs.

Function
REQ-015 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params), wrap to 0; v_cnt SHALL increment at each h_cnt wrap, wrap to 0 after V_TOTAL-1.
REQ-016 Active region SHALL be h_cnt<H_ACTIVE and v_cnt<V_ACTIVE; fb_rd=1 exactly in active region, else 0.
REQ-017 h_sync SHALL equal HS_POL when h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), else ~HS_POL; v_sync analogous on v_cnt with VS_POL.
REQ-018 fb_addr SHALL equal (v_cnt/SCALE)*(H_ACTIVE/SCALE)+h_cnt/SCALE, generated incrementally (row-base register, no multiplier); held at last value outside active region.
REQ-019 h_sync, v_sync, blank_b, x, y, red/green/blue, frame_start SHALL be registered and appear exactly RD_LAT+1 cycles after the counter state producing them, aligning colour with returned pixel.
REQ-020 blank_b SHALL be 1 in active region, 0 otherwise; red/green/blue SHALL be 0 whenever blank_b=0.
REQ-021 mode 0: red={p[7:5],p[7:5],p[7:6]}, green={p[4:2],p[4:2],p[4:3]}, blue={p[1:0]x4}; mode 1: red=green=blue=p.
REQ-022 At frame boundary (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1): en=0 SHALL park counters at (0,0) with fb_rd=0, outputs idle; en=1 SHALL continue; en changes mid-frame SHALL have no effect until boundary.
REQ-023 From parked state, en=1 SHALL start scanning at (0,0) next cycle; frame_start follows RD_LAT+1 cycles later.
REQ-024 mode SHALL be latched at frame boundary or park exit; mid-frame changes ignored.
REQ-025 x/y SHALL report raw counters (not scaled) on outputs; SCALE affects fb_addr only.

Reset
REQ-026 On rst: counters 0, parked state, pipeline cleared, fb_rd 0, fb_addr 0, h_sync ~HS_POL, v_sync ~VS_POL, blank_b 0, colours 0, x/y 0, frame_start 0, latched mode 0.
REQ-027 After rst release, block SHALL remain parked until en=1 sampled.
REQ-028 rst mid-frame SHALL take effect immediately, no partial line completion.

Structure
REQ-029 Package vga_pkg SHALL hold 640x480@60 timing constants, a timing-parameter struct, and colour-mode enum (RGB332, GRAY8).
REQ-030 One sub-module vga_delay_line SHALL be used: parametrised width/depth register pipeline aligning timing signals by RD_LAT+1.

Verification (bench params: H 8/2/2/2, V 4/1/1/1, total 14x7; RD_LAT 1 unless stated)
REQ-031 rst then en=1 -> frame_start 2 cycles after first fb_rd; h_sync low 2 cycles per 14; v_sync low 14 cycles per 98.
REQ-032 SCALE=2, memory returns addr -> fb_addr sequence 0,0,1,1,2,2,3,3 on lines 0 and 1, 4..7 doubled on lines 2-3.
REQ-033 mode 0, pixel 8'hE3 -> red FF, green 00, blue FF; mode 1, pixel 8'h5A -> all 5A; blanking -> all 00.
REQ-034 RD_LAT=3 -> first nonzero colour and blank_b rise 4 cycles after first fb_rd, x=0.
REQ-035 en dropped at v_cnt=2 -> frame completes, then fb_rd stays 0; en reasserted -> restart at (0,0).
REQ-036 rst at h_cnt=5, v_cnt=1 -> all outputs at reset values same cycle; stays parked until en.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, timing struct, colour modes and RGB332 expansion
package vga_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480 = '{640, 16, 96, 48, 480, 10, 2, 33};

    typedef enum logic {RGB332, GRAY8} color_mode_e;

    typedef enum logic {PARK, SCAN} scan_state_e;

    function automatic logic [23:0] colour(input logic [7:0] p, input color_mode_e m);
        return (m == GRAY8) ? {p, p, p}
                            : {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: D-stage register pipeline with per-bit reset value
module vga_delay_line #(
    parameter int W = 1,
    parameter int D = 1,
    parameter logic [W-1:0] RST = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] pipe [D];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) pipe[i] <= RST;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < D; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[D-1];

endmodule

// File: rtl/vga_scan_engine.sv
// vga_scan_engine: VGA raster timing, framebuffer fetch and colour pipeline
module vga_scan_engine
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_640X480.h_active,
    parameter int H_FP     = VGA_640X480.h_fp,
    parameter int H_SYNC   = VGA_640X480.h_sync,
    parameter int H_BP     = VGA_640X480.h_bp,
    parameter int V_ACTIVE = VGA_640X480.v_active,
    parameter int V_FP     = VGA_640X480.v_fp,
    parameter int V_SYNC   = VGA_640X480.v_sync,
    parameter int V_BP     = VGA_640X480.v_bp,
    parameter int SCALE    = 1,
    parameter int RD_LAT   = 1,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10,
    localparam int ADDR_W  = $clog2((H_ACTIVE / SCALE) * (V_ACTIVE / SCALE))
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    output logic              fb_rd,
    output logic [ADDR_W-1:0] fb_addr,
    input  logic [7:0]        pixel,
    output logic              h_sync,
    output logic              v_sync,
    output logic              sync_b,
    output logic              blank_b,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic [CW-1:0]     x,
    output logic [CW-1:0]     y,
    output logic              frame_start
);

    localparam int HW = H_ACTIVE / SCALE;
    localparam int SH = $clog2(SCALE);
    localparam logic [CW-1:0] HA    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] HS0   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS1   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] HE    = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CW-1:0] VA    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] VS0   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS1   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] VE    = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CW-1:0] SMASK = CW'(SCALE - 1);

    scan_state_e       state, state_nx;
    color_mode_e       mode_q;
    logic [CW-1:0]     h_cnt, v_cnt, v_nx;
    logic [ADDR_W-1:0] row_base, addr_q, addr_now;
    logic              h_end, v_end, f_end, active, hs_raw, vs_raw, fs_raw;
    logic [2*CW+3:0]   tm_d, tm_q;
    logic [1:0]        c_q;
    logic [23:0]       rgb;

    assign h_end    = h_cnt == HE;
    assign v_end    = v_cnt == VE;
    assign f_end    = h_end && v_end;
    assign v_nx     = v_cnt + 1'b1;
    assign addr_now = row_base + ADDR_W'(h_cnt >> SH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PARK;
        else     state <= state_nx;
    end

    // en is only honoured when parked or on the last pixel of a frame
    always_comb begin
        state_nx = (state == PARK) ? (en ? SCAN : PARK) : ((f_end && !en) ? PARK : SCAN);
    end

    always_comb begin
        active  = (state == SCAN) && (h_cnt < HA) && (v_cnt < VA);
        hs_raw  = (h_cnt >= HS0 && h_cnt < HS1) ? HS_POL : !HS_POL;
        vs_raw  = (v_cnt >= VS0 && v_cnt < VS1) ? VS_POL : !VS_POL;
        fs_raw  = (state == SCAN) && (h_cnt == '0) && (v_cnt == '0);
        fb_rd   = active;
        fb_addr = active ? addr_now : addr_q;
    end

    // row_base advances by one scaled row each time a SCALE-line group completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt    <= '0;
            v_cnt    <= '0;
            row_base <= '0;
            addr_q   <= '0;
            mode_q   <= RGB332;
        end else begin
            h_cnt    <= (state == SCAN && !h_end) ? h_cnt + 1'b1 : '0;
            v_cnt    <= (state != SCAN || f_end) ? '0 : v_cnt + CW'(h_end);
            row_base <= (state != SCAN || f_end) ? '0
                      : (h_end && (v_nx & SMASK) == '0) ? row_base + ADDR_W'(HW) : row_base;
            if (active) addr_q <= addr_now;
            if ((state == PARK) ? en : f_end) mode_q <= color_mode_e'(mode);
        end
    end

    assign tm_d = {hs_raw, vs_raw, active, fs_raw, h_cnt, v_cnt};

    vga_delay_line #(
        .W   (2*CW + 4),
        .D   (RD_LAT + 1),
        .RST ({!HS_POL, !VS_POL, {(2*CW + 2){1'b0}}})
    ) u_timing (
        .clk (clk),
        .rst (rst),
        .d   (tm_d),
        .q   (tm_q)
    );

    // colour control trails the fetch by RD_LAT so it meets the returned pixel
    vga_delay_line #(
        .W   (2),
        .D   (RD_LAT),
        .RST (2'b00)
    ) u_ctrl (
        .clk (clk),
        .rst (rst),
        .d   ({active, mode_q == GRAY8}),
        .q   (c_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rgb <= '0;
        else     rgb <= c_q[1] ? colour(pixel, c_q[0] ? GRAY8 : RGB332) : '0;
    end

    assign {h_sync, v_sync, blank_b, frame_start, x, y} = tm_q;
    assign {red, green, blue} = rgb;
    assign sync_b = 1'b0;

endmodule

// File: tb/tb_vga_scan_engine.sv
// tb_vga_scan_engine: randomized check of two scan engines against a frame-position model
module tb_vga_scan_engine;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       clk = 1'b0, rst = 1'b0, en = 1'b0, mode = 1'b0;
    logic [7:0] pix0 = '0, pix1 = '0;
    logic       rd0, rd1, hs0, hs1, vs0, vs1, sb0, sb1, bl0, bl1, fs0, fs1;
    logic [4:0] a0;
    logic [2:0] a1;
    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic [9:0] x0, y0, x1, y1;

    always #5 clk = ~clk;

    vga_scan_engine #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SCALE(1), .RD_LAT(1), .HS_POL(1'b0), .VS_POL(1'b0), .CW(10)
    ) u0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .fb_rd(rd0), .fb_addr(a0), .pixel(pix0),
        .h_sync(hs0), .v_sync(vs0), .sync_b(sb0), .blank_b(bl0), .red(r0), .green(g0),
        .blue(b0), .x(x0), .y(y0), .frame_start(fs0)
    );

    vga_scan_engine #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SCALE(2), .RD_LAT(3), .HS_POL(1'b0), .VS_POL(1'b0), .CW(10)
    ) u1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .fb_rd(rd1), .fb_addr(a1), .pixel(pix1),
        .h_sync(hs1), .v_sync(vs1), .sync_b(sb1), .blank_b(bl1), .red(r1), .green(g1),
        .blue(b1), .x(x1), .y(y1), .frame_start(fs1)
    );

    typedef struct {
        bit          hs, vs, bl, fs, m;
        int          x, y;
        logic [23:0] c0, c1;
    } exp_t;

    exp_t       hist[8];
    exp_t       idle;
    bit         run, mode_l, exp_rd;
    int         p, last_a0, last_a1;
    logic [7:0] mem0[32];
    logic [7:0] mem1[8];
    int         q0[2];
    int         q1[4];
    int         errs = 0, checks = 0;
    int         drop_t = -1, rst_t = -1, last_fs = -1, hs_lo = 0, vs_lo = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [23:0] colour(input logic [7:0] v, input bit m);
        return m ? {v, v, v} : {v[7:5], v[7:5], v[7:6], v[4:2], v[4:2], v[4:3], {4{v[1:0]}}};
    endfunction

    task automatic model_reset();
        run = 0; p = 0; mode_l = 0; exp_rd = 0;
        last_a0 = 0; last_a1 = 0;
        last_fs = -1; hs_lo = 0; vs_lo = 0;
        foreach (hist[i]) hist[i] = idle;
    endtask

    // the model tracks a linear position within the frame; h/v fall out by div/mod
    task automatic model_step();
        exp_t e;
        int   h, v;
        bit   act;
        if (rst) begin
            model_reset();
            return;
        end
        if (!run) begin
            if (en) begin run = 1; p = 0; mode_l = mode; end
        end else if (p == FT - 1) begin
            if (en) begin p = 0; mode_l = mode; end
            else begin run = 0; p = 0; end
        end else p++;
        h = p % HT;
        v = p / HT;
        act = run && h < HA && v < VA;
        if (act) begin
            last_a0 = v * HA + h;
            last_a1 = (v / 2) * (HA / 2) + h / 2;
        end
        e.hs = !(h >= HA + HF && h < HA + HF + HS);
        e.vs = !(v >= VA + VF && v < VA + VF + VS);
        e.bl = act;
        e.fs = run && p == 0;
        e.m  = mode_l;
        e.x  = h;
        e.y  = v;
        e.c0 = act ? colour(mem0[last_a0], mode_l) : 24'h0;
        e.c1 = act ? colour(mem1[last_a1], mode_l) : 24'h0;
        exp_rd = act;
        for (int i = 7; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = e;
    endtask

    task automatic compare_all();
        check("u0 fb_rd", 32'(rd0), 32'(exp_rd));
        check("u0 fb_addr", 32'(a0), 32'(last_a0));
        check("u0 h_sync", 32'(hs0), 32'(hist[2].hs));
        check("u0 v_sync", 32'(vs0), 32'(hist[2].vs));
        check("u0 sync_b", 32'(sb0), 32'(0));
        check("u0 blank_b", 32'(bl0), 32'(hist[2].bl));
        check("u0 frame_start", 32'(fs0), 32'(hist[2].fs));
        check("u0 x", 32'(x0), 32'(hist[2].x));
        check("u0 y", 32'(y0), 32'(hist[2].y));
        check("u0 rgb", 32'({r0, g0, b0}), 32'(hist[2].c0));
        check("u1 fb_rd", 32'(rd1), 32'(exp_rd));
        check("u1 fb_addr", 32'(a1), 32'(last_a1));
        check("u1 h_sync", 32'(hs1), 32'(hist[4].hs));
        check("u1 v_sync", 32'(vs1), 32'(hist[4].vs));
        check("u1 sync_b", 32'(sb1), 32'(0));
        check("u1 blank_b", 32'(bl1), 32'(hist[4].bl));
        check("u1 frame_start", 32'(fs1), 32'(hist[4].fs));
        check("u1 x", 32'(x1), 32'(hist[4].x));
        check("u1 y", 32'(y1), 32'(hist[4].y));
        check("u1 rgb", 32'({r1, g1, b1}), 32'(hist[4].c1));
    endtask

    initial begin
        idle = '{1, 1, 0, 0, 0, 0, 0, 24'h0, 24'h0};
        foreach (mem0[i]) mem0[i] = 8'($urandom);
        foreach (mem1[i]) mem1[i] = 8'($urandom);
        mem0[3] = 8'hE3;
        mem0[4] = 8'h5A;
        q0 = '{-1, -1};
        q1 = '{-1, -1, -1, -1};
        model_reset();
        #1 rst = 1'b1;
        for (int cyc = 0; cyc < 2400; cyc++) begin
            @(negedge clk);
            model_step();
            compare_all();
            if (hist[2].bl && hist[2].x == 3 && hist[2].y == 0 && !hist[2].m)
                check("rgb332 E3", 32'({r0, g0, b0}), 32'h00FF00FF);
            if (hist[2].bl && hist[2].x == 4 && hist[2].y == 0 && hist[2].m)
                check("gray 5A", 32'({r0, g0, b0}), 32'h005A5A5A);
            if (fs0) begin
                if (last_fs >= 0 && cyc - last_fs == FT) begin
                    check("h_sync low per frame", 32'(hs_lo), 32'(2 * VT));
                    check("v_sync low per frame", 32'(vs_lo), 32'(VS * HT));
                end
                hs_lo = 0; vs_lo = 0; last_fs = cyc;
            end
            hs_lo += int'(!hs0);
            vs_lo += int'(!vs0);
            // framebuffer with RD_LAT cycles of latency; idle reads return noise
            q0[1] = q0[0];
            q0[0] = rd0 ? int'(a0) : -1;
            pix0  = (q0[1] >= 0) ? mem0[q0[1]] : 8'($urandom);
            for (int i = 3; i > 0; i--) q1[i] = q1[i-1];
            q1[0] = rd1 ? int'(a1) : -1;
            pix1  = (q1[3] >= 0) ? mem1[q1[3]] : 8'($urandom);
            mode = 1'($urandom_range(0, 1));
            if (cyc < 8) en = 1'b0;
            else if (cyc < 300) en = 1'b1;
            else if (cyc < 1500) en = ($urandom_range(0, 19) != 0);
            else if (drop_t < 0) begin
                en = 1'b1;
                if (run && p == 2 * HT) begin en = 1'b0; drop_t = cyc; end
            end else if (cyc < drop_t + 150) en = 1'b0;
            else if (rst_t < 0 && cyc >= 1900 && run && p == HT + 5) begin
                rst = 1'b1;
                en = 1'b0;
                rst_t = cyc;
                #1;
                model_reset();
                compare_all();
            end else if (rst_t >= 0 && cyc < rst_t + 12) en = 1'b0;
            else en = 1'b1;
            rst = (cyc < 2) || (rst_t >= 0 && cyc < rst_t + 3);
        end
        check("reset injected", 32'(rst_t >= 0), 32'(1));
        check("en drop injected", 32'(drop_t >= 0), 32'(1));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
